seq_alu: RTL

SEQ_ALU -- requirements
Module: seq_alu

---
 rtl/seq_alu.sv | 190 +++++++++++++++++++
 1 files changed

// File: rtl/seq_alu.sv
// Multi-cycle ALU: logic/arith ops finish in 1 cycle, MULTU/DIVU iterate for WIDTH cycles.
// Latency 1 or WIDTH+1 cycles to done; starts arriving while busy are dropped.
module seq_alu #(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic [3:0]       ALUctl,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] result,
    output logic [WIDTH-1:0] hi,
    output logic             zero,
    output logic             overflow,
    output logic             div_by_zero
);

    localparam int CW = (WIDTH > 2) ? $clog2(WIDTH) : 1;

    typedef enum logic [1:0] {
        S_IDLE,
        S_MUL,
        S_DIV,
        S_DONE
    } state_t;

    state_t             r_state;
    logic [CW-1:0]      r_cnt;
    logic [WIDTH-1:0]   r_a;
    logic [WIDTH-1:0]   r_b;
    logic [2*WIDTH-1:0] r_p;
    logic [WIDTH-1:0]   r_result;
    logic [WIDTH-1:0]   r_hi;
    logic               r_ovf;
    logic               r_dbz;
    logic               r_busy;
    logic               r_done;

    logic [WIDTH-1:0]   w_sum;
    logic [WIDTH-1:0]   w_diff;
    logic               w_ovf_add;
    logic               w_ovf_sub;
    logic [WIDTH-1:0]   w_res;
    logic               w_ovf;

    assign w_sum     = a + b;
    assign w_diff    = a - b;
    assign w_ovf_add = (a[WIDTH-1] == b[WIDTH-1]) && (w_sum[WIDTH-1] != a[WIDTH-1]);
    assign w_ovf_sub = (a[WIDTH-1] != b[WIDTH-1]) && (w_diff[WIDTH-1] != a[WIDTH-1]);

    always_comb begin
        w_res = '0;
        w_ovf = 1'b0;
        case (ALUctl)
            4'b0000: w_res = a & b;
            4'b0001: w_res = a | b;
            4'b0010: begin
                w_res = w_sum;
                w_ovf = w_ovf_add;
            end
            4'b0110: begin
                w_res = w_diff;
                w_ovf = w_ovf_sub;
            end
            // Sign of a-b corrected by its overflow gives a true signed compare.
            4'b0111: w_res = {{(WIDTH-1){1'b0}}, w_diff[WIDTH-1] ^ w_ovf_sub};
            4'b1100: w_res = ~(a | b);
            default: begin
                w_res = '0;
                w_ovf = 1'b0;
            end
        endcase
    end

    // Shift-add step: r_p holds {partial product, remaining multiplier bits}.
    logic [WIDTH:0]     w_mul_acc;
    logic [2*WIDTH-1:0] w_mul_next;

    assign w_mul_acc  = {1'b0, r_p[2*WIDTH-1:WIDTH]} + (r_p[0] ? {1'b0, r_a} : {(WIDTH+1){1'b0}});
    assign w_mul_next = {w_mul_acc, r_p[WIDTH-1:1]};

    // Restoring step: r_p holds {partial remainder, dividend/quotient shift register}.
    logic [WIDTH:0]     w_div_shift;
    logic [WIDTH:0]     w_div_trial;
    logic               w_div_ge;
    logic [2*WIDTH-1:0] w_div_next;

    assign w_div_shift = {r_p[2*WIDTH-1:WIDTH], r_p[WIDTH-1]};
    assign w_div_trial = w_div_shift - {1'b0, r_b};
    assign w_div_ge    = ~w_div_trial[WIDTH];
    assign w_div_next  = {(w_div_ge ? w_div_trial[WIDTH-1:0] : w_div_shift[WIDTH-1:0]),
                          r_p[WIDTH-2:0], w_div_ge};

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state  <= S_IDLE;
            r_cnt    <= '0;
            r_a      <= '0;
            r_b      <= '0;
            r_p      <= '0;
            r_result <= '0;
            r_hi     <= '0;
            r_ovf    <= 1'b0;
            r_dbz    <= 1'b0;
            r_busy   <= 1'b0;
            r_done   <= 1'b0;
        end else begin
            case (r_state)
                S_IDLE, S_DONE: begin
                    if (start) begin
                        r_a   <= a;
                        r_b   <= b;
                        r_cnt <= '0;
                        case (ALUctl)
                            4'b1000: begin
                                r_state <= S_MUL;
                                r_p     <= {{WIDTH{1'b0}}, b};
                                r_busy  <= 1'b1;
                                r_done  <= 1'b0;
                            end
                            4'b1001: begin
                                r_state <= S_DIV;
                                r_p     <= {{WIDTH{1'b0}}, a};
                                r_busy  <= 1'b1;
                                r_done  <= 1'b0;
                            end
                            default: begin
                                r_state  <= S_DONE;
                                r_result <= w_res;
                                r_hi     <= '0;
                                r_ovf    <= w_ovf;
                                r_dbz    <= 1'b0;
                                r_busy   <= 1'b0;
                                r_done   <= 1'b1;
                            end
                        endcase
                    end else begin
                        r_state <= S_IDLE;
                        r_done  <= 1'b0;
                    end
                end
                S_MUL: begin
                    r_p   <= w_mul_next;
                    r_cnt <= r_cnt + 1'b1;
                    if (r_cnt == CW'(WIDTH-1)) begin
                        r_state  <= S_DONE;
                        r_result <= w_mul_next[WIDTH-1:0];
                        r_hi     <= w_mul_next[2*WIDTH-1:WIDTH];
                        r_ovf    <= 1'b0;
                        r_dbz    <= 1'b0;
                        r_busy   <= 1'b0;
                        r_done   <= 1'b1;
                    end
                end
                S_DIV: begin
                    r_p   <= w_div_next;
                    r_cnt <= r_cnt + 1'b1;
                    // A zero divisor needs no special path: every trial succeeds,
                    // giving an all-ones quotient and the dividend as remainder.
                    if (r_cnt == CW'(WIDTH-1)) begin
                        r_state  <= S_DONE;
                        r_result <= w_div_next[WIDTH-1:0];
                        r_hi     <= w_div_next[2*WIDTH-1:WIDTH];
                        r_ovf    <= 1'b0;
                        r_dbz    <= (r_b == '0);
                        r_busy   <= 1'b0;
                        r_done   <= 1'b1;
                    end
                end
                default: begin
                    r_state <= S_IDLE;
                    r_busy  <= 1'b0;
                    r_done  <= 1'b0;
                end
            endcase
        end
    end

    assign busy        = r_busy;
    assign done        = r_done;
    assign result      = r_result;
    assign hi          = r_hi;
    assign zero        = (r_result == '0);
    assign overflow    = r_ovf;
    assign div_by_zero = r_dbz;

endmodule
